// File: rtl/anton_neopixel_apb_bridge.sv
// APB3 slave that turns 32-bit transfers into single-cycle byte strobes on the
// neopixel peripheral bus: byte, register and packed (4 pixels per word) windows.
//
// state | meaning
// IDLE  | waiting for an access phase; latches and decodes the transfer
// ISSUE | one bus slot visible per cycle; a write completes on its last slot
// DRAIN | waiting READ_LATENCY cycles for the last read bytes to return
// DONE  | PREADY high for one cycle with PRDATA/PSLVERR valid
module anton_neopixel_apb_bridge #(
  parameter int PIXELS_MAX   = 66,
  parameter int READ_LATENCY = 1
) (
  input  logic        busClk,
  input  logic        busRstN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [15:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [14:0] PIX_MAX   = 15'(PIXELS_MAX);
  localparam logic [1:0]  DRAIN_TOP = 2'(READ_LATENCY - 1);

  logic [1:0]  state;
  logic [15:2] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [1:0]  slot;
  logic [1:0]  drain_cnt;
  logic [2:0]  tag_pipe [0:4];
  logic [31:0] rd_acc;
  logic [31:0] rd_acc_nxt;

  logic [15:2] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_write;
  logic [11:0] cur_w;
  logic        cur_packed;
  logic        cur_reg;
  logic        cur_err;
  logic [1:0]  last_slot;
  logic [1:0]  nxt_slot;
  logic [13:0] pix_base;
  logic [13:0] slot_pix;
  logic [13:0] slot_addr;
  logic        slot_skip;
  logic [7:0]  slot_data;
  logic [1:0]  slot_lane;
  logic        access;
  logic        do_issue;
  logic        unused_paddr;

  assign unused_paddr = ^PADDR[1:0];
  assign access = PSEL && PENABLE;

  // In IDLE the first slot is set up straight from the APB inputs; later slots
  // come from the latched copy so mid-transfer bus changes are ignored.
  always_comb begin
    cur_addr   = (state == ST_IDLE) ? PADDR[15:2] : addr_q;
    cur_wdata  = (state == ST_IDLE) ? PWDATA : wdata_q;
    cur_write  = (state == ST_IDLE) ? PWRITE : write_q;
    cur_w      = cur_addr[13:2];
    cur_packed = cur_addr[15];
    cur_reg    = (cur_addr[15:14] == 2'b01);
    pix_base   = {cur_w, 2'b00};
    last_slot  = cur_packed ? 2'd3 : 2'd0;
    nxt_slot   = (state == ST_IDLE) ? 2'd0 : slot + 2'd1;
    slot_pix   = pix_base + {12'd0, nxt_slot};
    if (cur_packed)   cur_err = ({1'b0, pix_base} >= PIX_MAX);
    else if (cur_reg) cur_err = (cur_addr[13:4] != 10'd0);
    else              cur_err = ({3'b000, cur_w} >= PIX_MAX);
    if (cur_packed)   slot_addr = slot_pix;
    else if (cur_reg) slot_addr = 14'h2000 | {12'd0, cur_addr[3:2]};
    else              slot_addr = {2'b00, cur_w};
    slot_skip = cur_packed && ({1'b0, slot_pix} >= PIX_MAX);
    slot_lane = cur_packed ? nxt_slot : 2'd0;
    slot_data = cur_packed ? cur_wdata[{nxt_slot, 3'b000} +: 8] : cur_wdata[7:0];
    do_issue  = ((state == ST_IDLE) && access && !cur_err) ||
                ((state == ST_ISSUE) && (slot != last_slot));
  end

  // Tag = {capture, lane}; it reaches stage READ_LATENCY when its byte is valid.
  always_comb begin
    rd_acc_nxt = rd_acc;
    if (tag_pipe[READ_LATENCY][2])
      rd_acc_nxt[{tag_pipe[READ_LATENCY][1:0], 3'b000} +: 8] = busDataOut;
  end

  always_ff @(posedge busClk or negedge busRstN) begin
    if (!busRstN) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      slot      <= '0;
      drain_cnt <= '0;
      rd_acc    <= '0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      busAddr   <= '0;
      busDataIn <= '0;
      busWrite  <= 1'b0;
      busRead   <= 1'b0;
      for (int k = 0; k < 5; k++) tag_pipe[k] <= '0;
    end else begin
      busWrite    <= 1'b0;
      busRead     <= 1'b0;
      tag_pipe[0] <= '0;
      for (int k = 1; k < 5; k++) tag_pipe[k] <= tag_pipe[k-1];
      rd_acc      <= rd_acc_nxt;

      if (do_issue) begin
        if (!slot_skip) begin
          busAddr  <= slot_addr;
          busWrite <= cur_write;
          busRead  <= !cur_write;
          if (cur_write) busDataIn <= slot_data;
        end
        tag_pipe[0] <= {!cur_write && !slot_skip, slot_lane};
        if (cur_write && (nxt_slot == last_slot)) begin
          PREADY  <= 1'b1;
          PSLVERR <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (access) begin
            addr_q  <= PADDR[15:2];
            wdata_q <= PWDATA;
            write_q <= PWRITE;
            rd_acc  <= '0;
            slot    <= '0;
            if (cur_err) begin
              state   <= ST_DONE;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              if (!PWRITE) PRDATA <= '0;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (slot == last_slot) begin
            PREADY <= 1'b0;
            if (write_q) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_TOP;
            end
          end else begin
            slot <= slot + 2'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state   <= ST_DONE;
            PREADY  <= 1'b1;
            PSLVERR <= 1'b0;
            PRDATA  <= rd_acc_nxt;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        default: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
